mcdf_formatter: RTL and testbench

Receive-side partner of the MCDF arbiter: requests a channel grant, acknowledges it, collects one packet of 32-bit words from the arbiter, and buffers it. Once the whole packet is captured, it presents the packet to the downstream consumer with a req/grant handshake, framed by start and end strobes. It sits between the arbiter and the MCDF output port and handles one packet at a time.

---
 rtl/mcdf_formatter.sv | 168 ++++++++++++++++
 tb/tb_mcdf_formatter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mcdf_formatter.sv
// MCDF receive-side formatter: collects one packet from the arbiter into a buffer and replays it downstream.
// Optional idle-timeout abort in RECV is enabled by defining FMT_TIMEOUT_EN.
module mcdf_formatter #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a2f_req_i,
  input  logic [1:0]  a2f_id_i,
  input  logic [2:0]  a2f_pkglen_sel_i,
  input  logic        a2f_val_i,
  input  logic [31:0] a2f_data_i,
  input  logic        a2f_end_i,
  output logic        f2a_id_req_o,
  output logic        f2a_ack_o,
  output logic        fmt_req_o,
  input  logic        fmt_grant_i,
  output logic [1:0]  fmt_chid_o,
  output logic [5:0]  fmt_length_o,
  output logic [31:0] fmt_data_o,
  output logic        fmt_start_o,
  output logic        fmt_end_o,
  output logic        fmt_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, IDREQ, ACK, RECV, SREQ, SEND} state_t;

  state_t      state, state_next;
  logic [1:0]  chid;
  logic [5:0]  target_len;
  logic [5:0]  count;
  logic [5:0]  length_q;
  logic [5:0]  rd_ptr;
  logic [31:0] data_q;
  logic [31:0] buffer [DEPTH];
  logic [5:0]  recv_cnt_next;
  logic        recv_exit;
  logic        last_word;
  logic        timeout_hit;

  if (DEPTH < 32 || TIMEOUT < 1) begin : g_param_check
    $error("mcdf_formatter: DEPTH must be >= 32 and TIMEOUT >= 1");
  end

  function automatic logic [5:0] decode_len(input logic [2:0] sel);
    if (sel[2] || sel[1:0] == 2'd3) return 6'd32;
    else return 6'd4 << sel[1:0];
  endfunction

  assign recv_cnt_next = count + {5'd0, a2f_val_i};
  assign recv_exit     = a2f_end_i || (recv_cnt_next == target_len);
  assign last_word     = (rd_ptr == length_q - 6'd1);

  assign fmt_chid_o   = chid;
  assign fmt_length_o = length_q;
  assign fmt_data_o   = data_q;

`ifdef FMT_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_cnt;
  logic          err_q;

  assign timeout_hit = (state == RECV) && !a2f_val_i && !a2f_end_i &&
                       (idle_cnt == IW'(TIMEOUT - 1));
  assign fmt_err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state != RECV || a2f_val_i) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fmt_err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (a2f_req_i) state_next = IDREQ;
      IDREQ: state_next = ACK;
      ACK:   state_next = RECV;
      RECV: begin
        // An end marker with no stored word drops the packet silently.
        if (recv_exit)        state_next = (recv_cnt_next == 6'd0) ? IDLE : SREQ;
        else if (timeout_hit) state_next = IDLE;
      end
      SREQ:  if (fmt_grant_i) state_next = SEND;
      SEND:  if (last_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    f2a_id_req_o = 1'b0;
    f2a_ack_o    = 1'b0;
    fmt_req_o    = 1'b0;
    fmt_start_o  = 1'b0;
    fmt_end_o    = 1'b0;
    case (state)
      IDREQ: f2a_id_req_o = 1'b1;
      ACK:   f2a_ack_o    = 1'b1;
      SREQ:  fmt_req_o    = 1'b1;
      SEND: begin
        fmt_start_o = (rd_ptr == 6'd0);
        fmt_end_o   = last_word;
      end
      default: ;
    endcase
  end

  // Packet storage carries no reset; stale contents are never read back.
  always_ff @(posedge clk_i) begin
    if (state == RECV && a2f_val_i) buffer[AW'(count)] <= a2f_data_i;
  end

  // Output words are registered one cycle ahead so data_q holds between packets.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chid       <= 2'd0;
      target_len <= 6'd0;
      count      <= 6'd0;
      length_q   <= 6'd0;
      rd_ptr     <= 6'd0;
      data_q     <= 32'd0;
    end else begin
      case (state)
        ACK: begin
          chid       <= a2f_id_i;
          target_len <= decode_len(a2f_pkglen_sel_i);
          count      <= 6'd0;
        end
        RECV: begin
          if (a2f_val_i) count    <= recv_cnt_next;
          if (recv_exit) length_q <= recv_cnt_next;
        end
        SREQ: begin
          if (fmt_grant_i) begin
            rd_ptr <= 6'd0;
            data_q <= buffer[0];
          end
        end
        SEND: begin
          if (!last_word) begin
            rd_ptr <= rd_ptr + 6'd1;
            data_q <= buffer[AW'(rd_ptr + 6'd1)];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_formatter.sv
// Directed self-checking bench for mcdf_formatter; inputs and samples both happen on the falling edge.
module tb_mcdf_formatter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a2f_req_i;
  logic [1:0]  a2f_id_i;
  logic [2:0]  a2f_pkglen_sel_i;
  logic        a2f_val_i;
  logic [31:0] a2f_data_i;
  logic        a2f_end_i;
  logic        f2a_id_req_o;
  logic        f2a_ack_o;
  logic        fmt_req_o;
  logic        fmt_grant_i;
  logic [1:0]  fmt_chid_o;
  logic [5:0]  fmt_length_o;
  logic [31:0] fmt_data_o;
  logic        fmt_start_o;
  logic        fmt_end_o;
  logic        fmt_err_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastData = 32'd0;

  mcdf_formatter #(.DEPTH(32), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a2f_req_i(a2f_req_i), .a2f_id_i(a2f_id_i), .a2f_pkglen_sel_i(a2f_pkglen_sel_i),
    .a2f_val_i(a2f_val_i), .a2f_data_i(a2f_data_i), .a2f_end_i(a2f_end_i),
    .f2a_id_req_o(f2a_id_req_o), .f2a_ack_o(f2a_ack_o),
    .fmt_req_o(fmt_req_o), .fmt_grant_i(fmt_grant_i),
    .fmt_chid_o(fmt_chid_o), .fmt_length_o(fmt_length_o), .fmt_data_o(fmt_data_o),
    .fmt_start_o(fmt_start_o), .fmt_end_o(fmt_end_o), .fmt_err_o(fmt_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_id_req"}, f2a_id_req_o, 0);
    checkOutput({tag, "_ack"},    f2a_ack_o, 0);
    checkOutput({tag, "_req"},    fmt_req_o, 0);
    checkOutput({tag, "_chid"},   fmt_chid_o, 0);
    checkOutput({tag, "_length"}, fmt_length_o, 0);
    checkOutput({tag, "_data"},   fmt_data_o, 0);
    checkOutput({tag, "_start"},  fmt_start_o, 0);
    checkOutput({tag, "_end"},    fmt_end_o, 0);
    checkOutput({tag, "_err"},    fmt_err_o, 0);
  endtask

  // Request arbitration from IDLE and leave the DUT at its first RECV cycle.
  task automatic startPacket(input logic [1:0] id, input logic [2:0] sel);
    a2f_id_i = id;
    a2f_pkglen_sel_i = sel;
    a2f_req_i = 1'b1;
    tick();
    checkOutput("id_req", f2a_id_req_o, 1);
    checkOutput("ack_early", f2a_ack_o, 0);
    a2f_req_i = 1'b0;
    tick();
    checkOutput("ack", f2a_ack_o, 1);
    checkOutput("id_req_drop", f2a_id_req_o, 0);
    tick();
  endtask

  task automatic applyStimulus(input int n, input bit endLast, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      a2f_val_i  = 1'b1;
      a2f_data_i = base + 32'(i);
      a2f_end_i  = endLast && (i == n - 1);
      tick();
    end
    a2f_val_i = 1'b0;
    a2f_end_i = 1'b0;
  endtask

  // Entered at the first SREQ cycle; checks stopAt words (stopAt < len leaves the DUT mid-SEND).
  task automatic drainPacket(input logic [1:0] id, input int len, input logic [31:0] base,
                             input int delay, input int stopAt);
    for (int d = 0; d < delay; d++) begin
      checkOutput("req_hold", fmt_req_o, 1);
      checkOutput("chid_hold", fmt_chid_o, 32'(id));
      checkOutput("length_hold", fmt_length_o, 32'(len));
      checkOutput("data_hold", fmt_data_o, lastData);
      tick();
    end
    checkOutput("req", fmt_req_o, 1);
    checkOutput("chid", fmt_chid_o, 32'(id));
    checkOutput("length", fmt_length_o, 32'(len));
    fmt_grant_i = 1'b1;
    tick();
    fmt_grant_i = 1'b0;
    for (int w = 0; w < stopAt; w++) begin
      if (w > 0) tick();
      checkOutput("data", fmt_data_o, base + 32'(w));
      checkOutput("start", fmt_start_o, 32'(w == 0));
      checkOutput("end", fmt_end_o, 32'(w == len - 1));
      checkOutput("req_off", fmt_req_o, 0);
      checkOutput("chid_send", fmt_chid_o, 32'(id));
      checkOutput("length_send", fmt_length_o, 32'(len));
    end
    if (stopAt == len) begin
      lastData = base + 32'(len - 1);
      tick();
      checkOutput("post_start", fmt_start_o, 0);
      checkOutput("post_end", fmt_end_o, 0);
      checkOutput("post_req", fmt_req_o, 0);
      checkOutput("post_data", fmt_data_o, lastData);
    end
  endtask

  initial begin
    int errCount;
    int errAt;
    int reqSeen;

    rst_i = 1'b1;
    a2f_req_i = 1'b0; a2f_id_i = 2'd0; a2f_pkglen_sel_i = 3'd0;
    a2f_val_i = 1'b0; a2f_data_i = 32'd0; a2f_end_i = 1'b0; fmt_grant_i = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    rst_i = 1'b0;
    tick();

    $display("[TB] 8-word packet, immediate grant");
    startPacket(2'd1, 3'b001);
    applyStimulus(8, 1'b1, 32'h1000_0000);
    drainPacket(2'd1, 8, 32'h1000_0000, 0, 8);

    $display("[TB] 4-word packet, grant delayed 10 cycles");
    startPacket(2'd2, 3'b000);
    applyStimulus(4, 1'b0, 32'h2000_0000);
    drainPacket(2'd2, 4, 32'h2000_0000, 10, 4);

    $display("[TB] 16-word length, short packet of 5");
    startPacket(2'd3, 3'b010);
    applyStimulus(5, 1'b1, 32'h3000_0000);
    drainPacket(2'd3, 5, 32'h3000_0000, 0, 5);

    $display("[TB] end with no data, then extra val after full packet");
    startPacket(2'd0, 3'b000);
    a2f_end_i = 1'b1;
    tick();
    a2f_end_i = 1'b0;
    checkOutput("discard_req", fmt_req_o, 0);
    checkOutput("discard_id_req", f2a_id_req_o, 0);
    startPacket(2'd1, 3'b000);
    applyStimulus(4, 1'b0, 32'h4000_0000);
    a2f_val_i = 1'b1; a2f_data_i = 32'hDEAD_BEEF; a2f_end_i = 1'b1;
    tick();
    a2f_val_i = 1'b0; a2f_end_i = 1'b0;
    drainPacket(2'd1, 4, 32'h4000_0000, 0, 4);

    $display("[TB] 1-word packet");
    startPacket(2'd3, 3'b000);
    applyStimulus(1, 1'b1, 32'h5000_0000);
    drainPacket(2'd3, 1, 32'h5000_0000, 0, 1);

    $display("[TB] 32-word packet with reset mid-send");
    startPacket(2'd2, 3'b111);
    applyStimulus(32, 1'b0, 32'h6000_0000);
    drainPacket(2'd2, 32, 32'h6000_0000, 3, 10);
    rst_i = 1'b1;
    #1;
    checkAllZero("midrst");
    tick();
    rst_i = 1'b0;
    lastData = 32'd0;
    tick();
    startPacket(2'd1, 3'b001);
    applyStimulus(8, 1'b1, 32'h7000_0000);
    drainPacket(2'd1, 8, 32'h7000_0000, 0, 8);

    $display("[TB] 3 words then idle in RECV");
    startPacket(2'd1, 3'b010);
    applyStimulus(3, 1'b0, 32'h8000_0000);
    errCount = 0; errAt = 0; reqSeen = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (fmt_err_o === 1'b1) begin
        if (errCount == 0) errAt = k;
        errCount++;
      end
      if (fmt_req_o === 1'b1) reqSeen++;
    end
    checkOutput("idle_req_seen", reqSeen, 0);
`ifdef FMT_TIMEOUT_EN
    checkOutput("timeout_err_count", errCount, 1);
    checkOutput("timeout_err_cycle", errAt, 64);
`else
    checkOutput("no_timeout_err", errCount, 0);
    applyStimulus(1, 1'b1, 32'h8000_0003);
    drainPacket(2'd1, 4, 32'h8000_0000, 0, 4);
`endif

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
